// File: rtl/drive_supervisor.sv
// rtl/drive_supervisor.sv - chase-robot mode supervisor: sequencing, parameter latch, speed gating and frame watchdog
// Soft speed ramp is built only when DRIVE_SUPERVISOR_RAMP_EN is defined.
module drive_supervisor #(
  parameter int NUM_MOTORS = 2,
  parameter int SPEED_W    = 9,
  parameter int PARAM_W    = 14,
  parameter int WDT_CYCLES = 6500000,
  parameter int RAMP_DIV   = 65000,
  parameter int RAMP_STEP  = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic                          confirm_in,
  input  logic                          activate_in,
  input  logic                          pause_in,
  input  logic                          frame_done_in,
  input  logic [PARAM_W-1:0]            params_in,
  input  logic [NUM_MOTORS*SPEED_W-1:0] speed_in,
  output logic [NUM_MOTORS*SPEED_W-1:0] speed_out,
  output logic [NUM_MOTORS-1:0]         enable_out,
  output logic [PARAM_W-1:0]            params_out,
  output logic [2:0]                    state_out,
  output logic                          track_out,
  output logic                          move_out,
  output logic                          fault_out
);

  localparam int SV_W  = NUM_MOTORS * SPEED_W;
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_SELECTED  = 3'd1,
    ST_CONFIRMED = 3'd2,
    ST_MOVE      = 3'd3,
    ST_PAUSE     = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  state_t                     state, state_nxt;
  logic                       confirm_q, activate_q;
  logic                       conf_rise, act_rise, wdt_expire, speed_zero;
  logic [WDT_W-1:0]           wdt_cnt;
  logic [SV_W-1:0]            speed_nxt;
  logic signed [SPEED_W-1:0]  ch_tgt;

  assign conf_rise  = confirm_in & ~confirm_q;
  assign act_rise   = activate_in & ~activate_q;
  // A frame pulse in the expiry cycle rescues MOVE.
  assign wdt_expire = (wdt_cnt == WDT_LAST) & ~frame_done_in;
  assign speed_zero = ~|speed_out;
  assign state_out  = state;

`ifdef DRIVE_SUPERVISOR_RAMP_EN
  localparam int RDIV_W = $clog2(RAMP_DIV + 1);
  localparam logic [RDIV_W-1:0]       RDIV_LAST = RDIV_W'(RAMP_DIV - 1);
  localparam logic signed [SPEED_W:0] STEP_POS  = (SPEED_W+1)'(RAMP_STEP);
  localparam logic signed [SPEED_W:0] STEP_NEG  = -STEP_POS;
  localparam logic signed [SPEED_W-1:0] STEP_S  = SPEED_W'(RAMP_STEP);

  logic [RDIV_W-1:0]         ramp_cnt;
  logic                      tick;
  logic signed [SPEED_W-1:0] ch_cur;
  logic signed [SPEED_W:0]   ch_diff;

  assign tick = (ramp_cnt == RDIV_LAST);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)    ramp_cnt <= '0;
    else if (tick) ramp_cnt <= '0;
    else           ramp_cnt <= ramp_cnt + RDIV_W'(1);
  end
`else
  logic unused_ramp_cfg;
  assign unused_ramp_cfg = (RAMP_DIV > 0) ^ (RAMP_STEP > 0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:      if (conf_rise) state_nxt = ST_SELECTED;
      ST_SELECTED:  if (!activate_in) state_nxt = ST_INIT;
                    else if (conf_rise) state_nxt = ST_CONFIRMED;
      ST_CONFIRMED: if (act_rise && !pause_in) state_nxt = ST_MOVE;
      ST_MOVE:      if (wdt_expire) state_nxt = ST_FAULT;
                    else if (!activate_in || pause_in) state_nxt = ST_PAUSE;
      ST_PAUSE:     if (conf_rise) state_nxt = ST_SELECTED;
                    else if (activate_in && !pause_in && speed_zero) state_nxt = ST_MOVE;
      ST_FAULT:     if (conf_rise) state_nxt = ST_PAUSE;
      default:      state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    speed_nxt = speed_out;
    ch_tgt    = '0;
`ifdef DRIVE_SUPERVISOR_RAMP_EN
    ch_cur    = '0;
    ch_diff   = '0;
`endif
    for (int i = 0; i < NUM_MOTORS; i++) begin
      ch_tgt = (state == ST_MOVE) ? speed_in[i*SPEED_W +: SPEED_W] : '0;
`ifdef DRIVE_SUPERVISOR_RAMP_EN
      // One extra bit keeps the distance exact across the full signed range.
      ch_cur  = speed_out[i*SPEED_W +: SPEED_W];
      ch_diff = {ch_tgt[SPEED_W-1], ch_tgt} - {ch_cur[SPEED_W-1], ch_cur};
      if (tick) begin
        if (ch_diff > STEP_POS)      speed_nxt[i*SPEED_W +: SPEED_W] = ch_cur + STEP_S;
        else if (ch_diff < STEP_NEG) speed_nxt[i*SPEED_W +: SPEED_W] = ch_cur - STEP_S;
        else                         speed_nxt[i*SPEED_W +: SPEED_W] = ch_tgt;
      end
`else
      speed_nxt[i*SPEED_W +: SPEED_W] = ch_tgt;
`endif
    end
    if (state_nxt == ST_FAULT) speed_nxt = '0;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      confirm_q  <= 1'b0;
      activate_q <= 1'b0;
      wdt_cnt    <= '0;
      params_out <= '0;
      speed_out  <= '0;
      enable_out <= '0;
      track_out  <= 1'b0;
      move_out   <= 1'b0;
      fault_out  <= 1'b0;
    end else begin
      state      <= state_nxt;
      confirm_q  <= confirm_in;
      activate_q <= activate_in;
      track_out  <= (state_nxt == ST_CONFIRMED) || (state_nxt == ST_MOVE) || (state_nxt == ST_PAUSE);
      move_out   <= (state_nxt == ST_MOVE);
      fault_out  <= (state_nxt == ST_FAULT);
      if (state != ST_MOVE) params_out <= params_in;
      if (state != ST_MOVE || frame_done_in) wdt_cnt <= '0;
      else                                   wdt_cnt <= wdt_cnt + WDT_W'(1);
      speed_out <= speed_nxt;
      for (int i = 0; i < NUM_MOTORS; i++)
        enable_out[i] <= |speed_nxt[i*SPEED_W +: SPEED_W];
    end
  end

endmodule

// File: doc/drive_supervisor.md
# drive_supervisor

Parametrised operating-mode supervisor for the chase robot. It sits between the tracker/control loop and the motor drivers. It sequences the INITIALIZE → SELECTED → CONFIRMED → MOVE/PAUSE flow from confirm/activate/pause inputs and latches control parameters outside MOVE. It gates and soft-ramps N motor speed channels and forces a FAULT stop when camera frames stop arriving.

## Interface
- NUM_MOTORS, 2, number of motor speed channels
- SPEED_W, 9, signed width of each speed channel
- PARAM_W, 14, width of control parameter word (Kp/Kd/mode)
- WDT_CYCLES, 6500000, max clocks in MOVE without frame_done_in (~3 frames at 65 MHz)
- RAMP_DIV, 65000, clocks per ramp tick
- RAMP_STEP, 4, max speed change per channel per ramp tick
- clk_in  in  1  system clock (65 MHz)
- rst_n  in  1  asynchronous, active-low reset
- confirm_in  in  1  synchronous, debounced level; only rising edges act
- activate_in  in  1  level; run enable
- pause_in  in  1  level; pause request
- frame_done_in  in  1  one-cycle pulse per camera frame
- params_in  in  PARAM_W  live parameter switches
- speed_in  in  NUM_MOTORS*SPEED_W  signed target speeds from control, channel i at [i*SPEED_W +: SPEED_W]
- speed_out  out  NUM_MOTORS*SPEED_W  ramped/gated signed speeds
- enable_out  out  NUM_MOTORS  per-channel driver enable
- params_out  out  PARAM_W  latched parameters
- state_out  out  3  current state code
- track_out  out  1  high in CONFIRMED, MOVE, PAUSE
- move_out  out  1  high in MOVE
- fault_out  out  1  high in FAULT

## Operation
- State codes: INIT=0, SELECTED=1, CONFIRMED=2, MOVE=3, PAUSE=4, FAULT=5. Codes 6 and 7 go to INIT.
- Edge detect: conf_rise = confirm_in & ~confirm_q. act_rise is formed the same way from activate_in.
- Transitions (first listed wins):
  - INIT: conf_rise → SELECTED.
  - SELECTED: ~activate_in → INIT; conf_rise → CONFIRMED.
  - CONFIRMED: act_rise & ~pause_in → MOVE.
  - MOVE: watchdog expiry → FAULT; ~activate_in | pause_in → PAUSE.
  - PAUSE: conf_rise → SELECTED; activate_in & ~pause_in & all speed_out==0 → MOVE.
  - FAULT: conf_rise → PAUSE.
- params_out <= params_in every clock in every state except MOVE. It is frozen in MOVE.
- Target per channel: speed_in in MOVE, 0 in all other states.
- Ramp:
  - A free-running tick counter pulses every RAMP_DIV clocks.
  - On each tick, every channel moves its current value toward its target.
  - If |target−cur| ≤ RAMP_STEP, cur = target. Otherwise cur ± RAMP_STEP.
  - The difference is computed at SPEED_W+1 bits, so there is no overflow at −2^(SPEED_W−1).
- FAULT: all channels cleared to 0 in the cycle of entry, with no ramp.
- enable_out[i] = (speed_out channel i != 0).
- Watchdog:
  - Counter cleared on MOVE entry, on frame_done_in, and in every non-MOVE state.
  - Otherwise it increments. Reaching WDT_CYCLES−1 is expiry.
  - If frame_done_in and expiry occur in the same cycle, frame_done_in wins.

## Timing
- All outputs are registered.
- Values on rst_n low: state INIT, speed_out 0, enable_out 0, params_out 0, watchdog 0, ramp counter 0, confirm_q 0, activate_q 0.
- Reset asserted mid-ramp zeroes outputs immediately (asynchronous).
- The state register updates on the clock edge that samples the triggering condition. state_out, track_out, move_out and fault_out reflect the new state one cycle after the input changes.
- speed_out changes only on ramp ticks, except on FAULT entry, when it is zero on the same edge the state becomes FAULT.
- enable_out follows speed_out with zero additional latency (it is registered from the next speed value).
- A held confirm_in produces exactly one transition.

## Configuration
- DRIVE_SUPERVISOR_RAMP_EN defined: the ramp behaves as above.
- DRIVE_SUPERVISOR_RAMP_EN undefined:
  - The ramp and tick counter are removed. speed_out = target, registered, with 1-cycle latency.
  - The PAUSE→MOVE speed==0 condition is satisfied one cycle after entering PAUSE.
  - FAULT behaviour is unchanged.

## Test plan
Bench parameters: NUM_MOTORS=2, SPEED_W=9, WDT_CYCLES=100, RAMP_DIV=4, RAMP_STEP=4.
- Sequencing: confirm pulse → SELECTED; second pulse → CONFIRMED (track_out=1); activate_in 0→1 → MOVE (move_out=1). Holding confirm_in high for 50 cycles gives only one step.
- Ramp up: in MOVE, speed_in = {+10, −10} → speed_out goes 4, 8, 10 and −4, −8, −10 on successive ticks (4 clocks apart). enable_out=2'b11 after the first tick.
- Pause: pause_in=1 → PAUSE, and speed ramps to 0. With pause_in=0 while speed≠0 the state stays PAUSE; it enters MOVE on the cycle after speeds reach 0.
- Watchdog: in MOVE with no frame_done_in for 100 cycles → FAULT, fault_out=1, speed_out=0 on the same edge. Pulses every 90 cycles keep MOVE. A pulse coincident with expiry also keeps MOVE.
- Params: params_in=14'h1ABC in CONFIRMED, then change to 14'h0123 in MOVE → params_out stays 14'h1ABC. It updates to 14'h0123 one cycle after entering PAUSE.
- Reset: rst_n low mid-ramp at speed 8 → all outputs 0 and state 0 immediately. Extreme target −256 ramps without wrap.
